// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
//   Round-robin owner of a shared intersection. Grants one approach at a time
//   and drives every approach light through GREEN -> YELLOW -> ALL_RED using a
//   single phase counter. It is the only source of the per-approach light state.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high
//   enable        in   1 = new grants allowed (never aborts YELLOW / ALL_RED)
//   car_req       in   [NUM_APPROACH-1:0] level car-detect per approach
//   light_state   out  [2i+1:2i] = approach i; 00 RED, 01 GREEN, 10 YELLOW
//   grant_idx     out  current or last granted approach
//   busy          out  1 whenever the scheduler is not idle
//   timer_expired out  one-cycle pulse on the first cycle after a timed phase ends
module intersection_phase_scheduler #(
  parameter int NUM_APPROACH = 4,
  parameter int CNT_W        = 8,
  parameter int GREEN_MIN    = 4,
  parameter int GREEN_MAX    = 12,
  parameter int YELLOW_TIME  = 3,
  parameter int ALLRED_TIME  = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_APPROACH-1:0]           car_req,
  output logic [2*NUM_APPROACH-1:0]         light_state,
  output logic [$clog2(NUM_APPROACH)-1:0]   grant_idx,
  output logic                              busy,
  output logic                              timer_expired
);

  localparam int IDX_W = $clog2(NUM_APPROACH);

  localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST    = CNT_W'(ALLRED_TIME - 1);

  // One extra bit so rrLast + offset never overflows before the wrap.
  localparam logic [IDX_W:0] NUM_EXT = (IDX_W + 1)'(NUM_APPROACH);

  typedef enum logic [1:0] {
    IDLE,
    GREEN,
    YELLOW,
    ALL_RED
  } phaseT;

  phaseT                    state;
  phaseT                    stateNext;
  logic [CNT_W-1:0]         phaseCnt;
  logic [CNT_W-1:0]         phaseCntNext;
  logic [IDX_W-1:0]         rrLast;
  logic [IDX_W-1:0]         rrLastNext;
  logic [IDX_W-1:0]         grantNext;
  logic [IDX_W-1:0]         winner;
  logic [IDX_W:0]           cand;
  logic                     winnerFound;
  logic                     ownReq;
  logic                     othersReq;
  logic                     gapOut;
  logic                     maxOut;
  logic                     expireNext;
  logic                     busyNext;
  logic [2*NUM_APPROACH-1:0] lightNext;

  // Round-robin search: first requester strictly after rrLast, wrapping.
  // The last candidate examined is rrLast itself, so a sole requester wins.
  always_comb begin
    winner      = rrLast;
    winnerFound = 1'b0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_APPROACH; i++) begin
      cand = {1'b0, rrLast} + (IDX_W + 1)'(i);
      if (cand >= NUM_EXT) begin
        cand = cand - NUM_EXT;
      end
      if (!winnerFound && car_req[cand[IDX_W-1:0]]) begin
        winner      = cand[IDX_W-1:0];
        winnerFound = 1'b1;
      end
    end
  end

  always_comb begin
    othersReq = 1'b0;
    for (int unsigned j = 0; j < NUM_APPROACH; j++) begin
      if (IDX_W'(j) != grant_idx) begin
        othersReq = othersReq | car_req[j];
      end
    end
    ownReq = car_req[grant_idx];
    gapOut = (phaseCnt >= GREEN_MIN_LAST) && (!ownReq || !enable);
    maxOut = (phaseCnt >= GREEN_MAX_LAST) && othersReq;
  end

  always_comb begin
    stateNext  = state;
    grantNext  = grant_idx;
    rrLastNext = rrLast;
    case (state)
      IDLE: begin
        if (enable && winnerFound) begin
          stateNext  = GREEN;
          grantNext  = winner;
          rrLastNext = winner;
        end
      end
      GREEN: begin
        if (gapOut || maxOut) begin
          stateNext = YELLOW;
        end
      end
      YELLOW: begin
        if (phaseCnt >= YELLOW_LAST) begin
          stateNext = ALL_RED;
        end
      end
      ALL_RED: begin
        if (phaseCnt >= ALLRED_LAST) begin
          if (enable && winnerFound) begin
            stateNext  = GREEN;
            grantNext  = winner;
            rrLastNext = winner;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Counter restarts on every state change (including ALL_RED -> GREEN);
  // in GREEN it parks at GREEN_MAX-1 so an unopposed green can hold forever.
  always_comb begin
    phaseCntNext = '0;
    if (stateNext == state) begin
      case (state)
        GREEN:   phaseCntNext = (phaseCnt >= GREEN_MAX_LAST) ? phaseCnt
                                                             : phaseCnt + CNT_W'(1);
        YELLOW,
        ALL_RED: phaseCntNext = phaseCnt + CNT_W'(1);
        default: phaseCntNext = '0;
      endcase
    end
  end

  // Outputs are derived from the next state so they register on the same edge.
  always_comb begin
    expireNext = (state != IDLE) && (stateNext != state);
    busyNext   = (stateNext != IDLE);
    lightNext  = '0;
    for (int unsigned j = 0; j < NUM_APPROACH; j++) begin
      if (IDX_W'(j) == grantNext) begin
        if (stateNext == GREEN) begin
          lightNext[2*j +: 2] = 2'b01;
        end else if (stateNext == YELLOW) begin
          lightNext[2*j +: 2] = 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      phaseCnt      <= '0;
      rrLast        <= IDX_W'(NUM_APPROACH - 1);
      grant_idx     <= '0;
      light_state   <= '0;
      busy          <= 1'b0;
      timer_expired <= 1'b0;
    end else begin
      state         <= stateNext;
      phaseCnt      <= phaseCntNext;
      rrLast        <= rrLastNext;
      grant_idx     <= grantNext;
      light_state   <= lightNext;
      busy          <= busyNext;
      timer_expired <= expireNext;
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
module tb_intersection_phase_scheduler;

  localparam int N    = 4;
  localparam int GMIN = 4;
  localparam int GMAX = 12;
  localparam int YT   = 3;
  localparam int AR   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] car_req;
  logic [7:0] light_state;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timer_expired;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .NUM_APPROACH(N),
    .CNT_W(8),
    .GREEN_MIN(GMIN),
    .GREEN_MAX(GMAX),
    .YELLOW_TIME(YT),
    .ALLRED_TIME(AR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .car_req(car_req),
    .light_state(light_state),
    .grant_idx(grant_idx),
    .busy(busy),
    .timer_expired(timer_expired)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: counts remaining time per phase instead of a state code.
  bit mGreenOn;
  int mShown;
  int mYelLeft;
  int mRedLeft;
  int mLast;
  int mGrant;
  bit mPulse;

  // Observed-behaviour tracker for the multi-cycle scenarios.
  int runIdx[$];
  int runLen[$];
  int gapLen[$];
  bit inGreen;
  int gapCnt;
  int yelCnt;
  int pulseCnt;

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic [7:0] light;
    logic       busyE;
    logic [1:0] grant;
    logic       te;
  } vecT;

  vecT vec[24];

  function automatic int pickWinner(input logic [3:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mGreenOn = 0; mShown = 0; mYelLeft = 0; mRedLeft = 0;
    mLast = N - 1; mGrant = 0; mPulse = 0;
  endtask

  task automatic startGreen(input logic [3:0] req);
    int w;
    w = pickWinner(req, mLast);
    mGreenOn = 1; mShown = 1; mGrant = w; mLast = w;
  endtask

  task automatic modelStep(input logic [3:0] req, input logic en);
    logic [3:0] ownMask;
    mPulse  = 0;
    ownMask = 4'b0001 << mGrant;
    if (mGreenOn) begin
      if ((mShown >= GMIN && (!req[mGrant] || !en)) ||
          (mShown >= GMAX && (req & ~ownMask) != 4'b0000)) begin
        mGreenOn = 0; mYelLeft = YT; mPulse = 1;
      end else begin
        mShown++;
      end
    end else if (mYelLeft > 0) begin
      mYelLeft--;
      if (mYelLeft == 0) begin
        mRedLeft = AR; mPulse = 1;
      end
    end else if (mRedLeft > 0) begin
      mRedLeft--;
      if (mRedLeft == 0) begin
        mPulse = 1;
        if (en && req != 4'b0000) startGreen(req);
      end
    end else if (en && req != 4'b0000) begin
      startGreen(req);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    logic [7:0] eLight;
    int nonRed;
    eLight = 8'h00;
    if (mGreenOn)          eLight = 8'h01 << (2 * mGrant);
    else if (mYelLeft > 0) eLight = 8'h02 << (2 * mGrant);
    checkVal({tag, ".light"}, 32'(light_state), 32'(eLight));
    checkVal({tag, ".busy"}, 32'(busy), 32'(mGreenOn || mYelLeft > 0 || mRedLeft > 0));
    checkVal({tag, ".grant"}, 32'(grant_idx), 32'(mGrant));
    checkVal({tag, ".expired"}, 32'(timer_expired), 32'(mPulse));
    nonRed = 0;
    for (int a = 0; a < N; a++) if (light_state[2*a +: 2] != 2'b00) nonRed++;
    checkVal({tag, ".oneNonRed"}, 32'(nonRed <= 1), 32'd1);
  endtask

  task automatic clearTrack();
    runIdx.delete(); runLen.delete(); gapLen.delete();
    inGreen = 0; gapCnt = 0; yelCnt = 0; pulseCnt = 0;
  endtask

  task automatic track();
    int g;
    g = -1;
    for (int a = 0; a < N; a++) begin
      if (light_state[2*a +: 2] == 2'b01) g = a;
      if (light_state[2*a +: 2] == 2'b10) yelCnt++;
    end
    if (timer_expired) pulseCnt++;
    if (g >= 0) begin
      if (inGreen && runIdx.size() > 0 && runIdx[runIdx.size()-1] == g) begin
        runLen[runLen.size()-1] = runLen[runLen.size()-1] + 1;
      end else begin
        if (runIdx.size() > 0) gapLen.push_back(gapCnt);
        runIdx.push_back(g);
        runLen.push_back(1);
      end
      inGreen = 1; gapCnt = 0;
    end else begin
      inGreen = 0; gapCnt++;
    end
  endtask

  task automatic cycle(input logic [3:0] req, input logic en);
    car_req = req;
    enable  = en;
    @(posedge clk);
    modelStep(req, en);
    @(negedge clk);
    checkModel("model");
    track();
  endtask

  task automatic applyReset();
    reset = 1'b1; car_req = 4'b0000; enable = 1'b0;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkModel("reset");
    reset = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rReq;
    logic       rEn;

    //            req      en    light  busy grant te
    vec[0]  = '{4'b1000, 1'b1, 8'h40, 1'b1, 2'd3, 1'b0};
    vec[1]  = '{4'b0000, 1'b1, 8'h40, 1'b1, 2'd3, 1'b0};
    vec[2]  = '{4'b0000, 1'b1, 8'h40, 1'b1, 2'd3, 1'b0};
    vec[3]  = '{4'b0000, 1'b1, 8'h40, 1'b1, 2'd3, 1'b0};
    vec[4]  = '{4'b0000, 1'b1, 8'h80, 1'b1, 2'd3, 1'b1};
    vec[5]  = '{4'b0000, 1'b1, 8'h80, 1'b1, 2'd3, 1'b0};
    vec[6]  = '{4'b0000, 1'b1, 8'h80, 1'b1, 2'd3, 1'b0};
    vec[7]  = '{4'b0000, 1'b1, 8'h00, 1'b1, 2'd3, 1'b1};
    vec[8]  = '{4'b0000, 1'b1, 8'h00, 1'b1, 2'd3, 1'b0};
    vec[9]  = '{4'b0000, 1'b1, 8'h00, 1'b0, 2'd3, 1'b1};
    vec[10] = '{4'b0000, 1'b1, 8'h00, 1'b0, 2'd3, 1'b0};
    vec[11] = '{4'b1111, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0};
    vec[12] = '{4'b1111, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0};
    vec[13] = '{4'b1111, 1'b1, 8'h01, 1'b1, 2'd0, 1'b0};
    vec[14] = '{4'b1111, 1'b0, 8'h01, 1'b1, 2'd0, 1'b0};
    vec[15] = '{4'b1111, 1'b0, 8'h01, 1'b1, 2'd0, 1'b0};
    vec[16] = '{4'b1111, 1'b0, 8'h01, 1'b1, 2'd0, 1'b0};
    vec[17] = '{4'b1111, 1'b0, 8'h02, 1'b1, 2'd0, 1'b1};
    vec[18] = '{4'b1111, 1'b0, 8'h02, 1'b1, 2'd0, 1'b0};
    vec[19] = '{4'b1111, 1'b0, 8'h02, 1'b1, 2'd0, 1'b0};
    vec[20] = '{4'b1111, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1};
    vec[21] = '{4'b1111, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
    vec[22] = '{4'b1111, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
    vec[23] = '{4'b1111, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};

    reset = 1'b1; enable = 1'b0; car_req = 4'b0000;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkModel("por");
    reset = 1'b0;

    // Single-cycle pulse from IDLE (minimum green), then enable gating.
    for (int i = 0; i < 24; i++) begin
      cycle(vec[i].req, vec[i].en);
      checkVal($sformatf("vec%0d.light", i), 32'(light_state), 32'(vec[i].light));
      checkVal($sformatf("vec%0d.busy", i), 32'(busy), 32'(vec[i].busyE));
      checkVal($sformatf("vec%0d.grant", i), 32'(grant_idx), 32'(vec[i].grant));
      checkVal($sformatf("vec%0d.expired", i), 32'(timer_expired), 32'(vec[i].te));
    end

    // Asynchronous reset in the middle of approach 1's green.
    applyReset();
    repeat (3) cycle(4'b0010, 1'b1);
    checkVal("t1.greenApp1", 32'(light_state), 32'h04);
    #2 reset = 1'b1;
    #1;
    checkVal("t1.asyncLight", 32'(light_state), 32'h00);
    checkVal("t1.asyncBusy", 32'(busy), 32'd0);
    checkVal("t1.asyncGrant", 32'(grant_idx), 32'd0);
    checkVal("t1.asyncExpired", 32'(timer_expired), 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkModel("t1.held");
    reset = 1'b0;

    // Held sole request, then dropped.
    applyReset();
    clearTrack();
    cycle(4'b0100, 1'b1);
    checkVal("t2.latency", 32'(light_state), 32'h10);
    repeat (19) cycle(4'b0100, 1'b1);
    repeat (8) cycle(4'b0000, 1'b1);
    checkVal("t2.runs", 32'(runIdx.size()), 32'd1);
    if (runIdx.size() >= 1) begin
      checkVal("t2.runIdx", 32'(runIdx[0]), 32'd2);
      checkVal("t2.runLen", 32'(runLen[0]), 32'd20);
    end
    checkVal("t2.yellowCycles", 32'(yelCnt), 32'd3);
    checkVal("t2.pulses", 32'(pulseCnt), 32'd3);
    checkVal("t2.idle", 32'(busy), 32'd0);

    // Max-out when a second approach arrives during the first green.
    applyReset();
    clearTrack();
    cycle(4'b0001, 1'b1);
    repeat (30) cycle(4'b0011, 1'b1);
    checkVal("t3.runsAtLeast2", 32'(runIdx.size() >= 2), 32'd1);
    if (runIdx.size() >= 2) begin
      checkVal("t3.firstIdx", 32'(runIdx[0]), 32'd0);
      checkVal("t3.firstLen", 32'(runLen[0]), 32'd12);
      checkVal("t3.gap", 32'(gapLen[0]), 32'(YT + AR));
      checkVal("t3.secondIdx", 32'(runIdx[1]), 32'd1);
    end

    // All approaches requesting: full rotation.
    applyReset();
    clearTrack();
    repeat (72) cycle(4'b1111, 1'b1);
    checkVal("t4.runs", 32'(runIdx.size()), 32'd5);
    if (runIdx.size() == 5) begin
      for (int k = 0; k < 5; k++)
        checkVal($sformatf("t4.order%0d", k), 32'(runIdx[k]), 32'(k % N));
      for (int k = 0; k < 4; k++) begin
        checkVal($sformatf("t4.len%0d", k), 32'(runLen[k]), 32'd12);
        checkVal($sformatf("t4.gap%0d", k), 32'(gapLen[k]), 32'(YT + AR));
      end
    end

    // Randomized traffic against the reference model.
    applyReset();
    rReq = 4'b0000;
    rEn  = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 7) == 0) rReq = 4'($urandom_range(0, 15));
      rEn = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 599) == 0) applyReset();
      else cycle(rReq, rEn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
